uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo_buf.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, default baud divider, frame sizes.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, 11-bit frame).
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_DIV = 87;
    localparam int unsigned DATA_BITS       = 8;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and status bundle of the buffered UART transmitter.
interface uart_tx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [LW-1:0] level;
    logic          busy;
    logic          ovf;
    logic          tx;

    modport master (
        output wr_en, wr_data,
        input  full, level, busy, ovf, tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, level, busy, ovf, tx
    );

endinterface

// File: rtl/uart_tx_fifo_buf.sv
// Transmit byte FIFO: storage, wrapping pointers, registered level/full/empty.
module uart_tx_fifo_buf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [LW-1:0] level_next;

    // full is the registered flag, so a pop on this edge cannot make room for a write
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with clock-enable gated baud timing.
// Optional feature macro: UART_TX_PARITY_EN inserts an even parity bit before stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    uart_tx_fifo_if.slave  bus
);
    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t     state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          busy_q;
    logic          ovf_q;
    logic          baud_done;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    head;
    logic [LW-1:0] level;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif

    uart_tx_fifo_buf #(
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_comb begin
        pop = 1'b0;
        if (ce && !fifo_empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if (state == ST_STOP && baud_done) begin
                pop = 1'b1;
            end
        end
    end

    // tx and busy follow the state one clk later, independent of ce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            ovf_q  <= ovf_q | (bus.wr_en & fifo_full);
            busy_q <= (state != ST_IDLE) || !fifo_empty;
            case (state)
                ST_START:  tx_q <= 1'b0;
                ST_DATA:   tx_q <= shreg[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: tx_q <= par_bit;
`endif
                default:   tx_q <= 1'b1;
            endcase

            if (ce) begin
                case (state)
                    ST_IDLE: begin
                        if (!fifo_empty) begin
                            state    <= ST_START;
                            shreg    <= head;
                            baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            par_bit  <= even_parity(head);
`endif
                        end
                    end
                    ST_START: begin
                        if (baud_done) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= ST_DATA;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (baud_done) begin
                            baud_cnt <= '0;
                            shreg    <= {1'b0, shreg[7:1]};
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= ST_PARITY;
`else
                                state   <= ST_STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (baud_done) begin
                            baud_cnt <= '0;
                            state    <= ST_STOP;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (baud_done) begin
                            baud_cnt <= '0;
                            if (!fifo_empty) begin
                                state    <= ST_START;
                                shreg    <= head;
`ifdef UART_TX_PARITY_EN
                                par_bit  <= even_parity(head);
`endif
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        baud_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.ovf   = ovf_q;
    assign bus.full  = fifo_full;
    assign bus.level = level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (CLK_DIV=4, FIFO_DEPTH=4).
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif

    logic clk;
    logic rst_n;
    logic ce;
    int unsigned n_cmp;
    int unsigned n_bad;
    logic tx_min;
    logic busy_any;

    uart_tx_fifo_if #(.FIFO_DEPTH(4)) bus ();

    uart_tx_fifo #(
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called just after an edge at offset `skip` into the frame's start bit.
    task automatic frame(input logic [7:0] b, input int unsigned skip,
                         input int unsigned len, input bit gate, input string tag);
        for (int unsigned idx = skip; idx < NB * len; idx++) begin
            int unsigned k;
            int unsigned c;
            k = idx / len;
            c = idx % len;
            if (c == 0 || c == len - 1)
                check($sformatf("%s_bit%0d_c%0d", tag, k, c), 32'(bus.tx), 32'(exp_bit(b, k)));
            if (k == NB - 1 && c == len - 1)
                check($sformatf("%s_busy_stop", tag), 32'(bus.busy), 32'd1);
            if (gate) ce = (idx % 2 == 0);
            tick();
            bus.wr_en = 1'b0;
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        ce          = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // reset values
        #12;
        check("rst_tx",    32'(bus.tx),    32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_full",  32'(bus.full),  32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_ovf",   32'(bus.ovf),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single byte 0xA5
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        check("a5_level", 32'(bus.level), 32'd1);
        check("a5_tx_e0", 32'(bus.tx), 32'd1);
        tick();
        check("a5_tx_e1", 32'(bus.tx), 32'd1);
        tick();
        check("a5_busy", 32'(bus.busy), 32'd1);
        frame(8'hA5, 0, 4, 1'b0, "a5");
        check("a5_idle_tx",   32'(bus.tx),   32'd1);
        check("a5_idle_busy", 32'(bus.busy), 32'd0);

        // burst of four on consecutive cycles
        bus.wr_en = 1'b1; bus.wr_data = 8'h00;
        tick();
        check("burst_lvl_w0", 32'(bus.level), 32'd1);
        bus.wr_data = 8'hFF;
        tick();
        check("burst_lvl_w1", 32'(bus.level), 32'd1);
        bus.wr_data = 8'h55;
        tick();
        check("burst_lvl_w2", 32'(bus.level), 32'd2);
        bus.wr_data = 8'h3C;
        tick();
        bus.wr_en = 1'b0;
        check("burst_lvl_w3", 32'(bus.level), 32'd3);
        frame(8'h00, 1, 4, 1'b0, "burst0");
        check("burst_lvl_f1", 32'(bus.level), 32'd2);
        frame(8'hFF, 0, 4, 1'b0, "burst1");
        frame(8'h55, 0, 4, 1'b0, "burst2");
        frame(8'h3C, 0, 4, 1'b0, "burst3");
        check("burst_idle_busy",  32'(bus.busy),  32'd0);
        check("burst_idle_level", 32'(bus.level), 32'd0);

        // overflow with ce held low
        ce = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h11; tick();
        bus.wr_data = 8'h22; tick();
        bus.wr_data = 8'h33; tick();
        bus.wr_data = 8'h44; tick();
        check("ovf_full4",  32'(bus.full),  32'd1);
        check("ovf_level4", 32'(bus.level), 32'd4);
        check("ovf_pre",    32'(bus.ovf),   32'd0);
        bus.wr_data = 8'h55; tick();
        check("ovf_full5",  32'(bus.full),  32'd1);
        check("ovf_level5", 32'(bus.level), 32'd4);
        check("ovf_set",    32'(bus.ovf),   32'd1);
        check("ovf_tx",     32'(bus.tx),    32'd1);
        // write while full on the pop edge is still dropped
        ce = 1'b1; bus.wr_data = 8'h66;
        tick();
        bus.wr_en = 1'b0;
        check("ovf_pop_level", 32'(bus.level), 32'd3);
        check("ovf_pop_full",  32'(bus.full),  32'd0);
        tick();
        frame(8'h11, 0, 4, 1'b0, "ovf11");
        frame(8'h22, 0, 4, 1'b0, "ovf22");
        frame(8'h33, 0, 4, 1'b0, "ovf33");
        frame(8'h44, 0, 4, 1'b0, "ovf44");
        check("ovf_end_tx",    32'(bus.tx),    32'd1);
        check("ovf_end_busy",  32'(bus.busy),  32'd0);
        check("ovf_end_level", 32'(bus.level), 32'd0);
        check("ovf_sticky",    32'(bus.ovf),   32'd1);

        // ce toggling every cycle: 8 clk per bit
        ce = 1'b0; bus.wr_en = 1'b1; bus.wr_data = 8'hC3;
        tick();
        bus.wr_en = 1'b0;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick();
        frame(8'hC3, 0, 8, 1'b1, "ce");
        ce = 1'b1;
        check("ce_idle_tx",   32'(bus.tx),   32'd1);
        check("ce_idle_busy", 32'(bus.busy), 32'd0);

        // reset during data bit 3 of 0x81
        bus.wr_en = 1'b1; bus.wr_data = 8'h81;
        tick();
        bus.wr_en = 1'b0;
        tick();
        tick();
        check("rstm_start", 32'(bus.tx), 32'd0);
        bus.wr_en = 1'b1; bus.wr_data = 8'h42;
        tick();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("rstm_bit3",  32'(bus.tx),    32'd0);
        check("rstm_level", 32'(bus.level), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstm_tx",    32'(bus.tx),    32'd1);
        check("rstm_lvl0",  32'(bus.level), 32'd0);
        check("rstm_busy",  32'(bus.busy),  32'd0);
        check("rstm_ovf",   32'(bus.ovf),   32'd0);
        check("rstm_full",  32'(bus.full),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tx_min = 1'b1;
        busy_any = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            tx_min   = tx_min & bus.tx;
            busy_any = busy_any | bus.busy;
        end
        check("rstm_after_tx",   32'(tx_min),   32'd1);
        check("rstm_after_busy", 32'(busy_any), 32'd0);

`ifdef UART_TX_PARITY_EN
        bus.wr_en = 1'b1; bus.wr_data = 8'h07;
        tick();
        bus.wr_data = 8'h03;
        tick();
        bus.wr_en = 1'b0;
        frame(8'h07, 1, 4, 1'b0, "par07");
        frame(8'h03, 0, 4, 1'b0, "par03");
        check("par_idle_busy", 32'(bus.busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
